wt_dcache_rd_arb: RTL
=====================

// Module: wt_dcache_rd_arb
// PURPOSE
// Read-port arbiter/scheduler for the write-through L1 dcache memory arrays. It shares the
// single tag/data SRAM read port between the load unit and PTW controllers (high priority)
// and the write buffer (low priority). It also resolves conflicts with the refill/invalidate
// cacheline port and the single-word write port. Each grant is tracked through a 1-cycle
// response stage, so read data is routed back to the requester that issued it.
// PARAMETERS
// NumPorts     3                    number of read requesters
// TagWidth     DCACHE_TAG_WIDTH     tag field width
// IdxWidth     DCACHE_CL_IDX_WIDTH  cacheline index width
// OffWidth     DCACHE_OFFSET_WIDTH  byte offset width
// StarveLimit  16                   low-prio wait cycles before forced grant (>=2)
// PORTS
// clk_i            in   1                   clock
// rst_ni           in   1                   asynchronous reset, active low
// clr_i            in   1                   synchronous clear, active high
// rd_req_i         in   NumPorts            read request per port, held until acked
// rd_prio_i        in   NumPorts            1 = high priority port (static)
// rd_tag_only_i    in   NumPorts            request reads tag array only
// rd_tag_i         in   NumPorts*TagWidth   tag per port
// rd_idx_i         in   NumPorts*IdxWidth   index per port
// rd_off_i         in   NumPorts*OffWidth   offset per port
// rd_ack_o         out  NumPorts            one-hot grant, same cycle as request
// rsp_vld_o        out  NumPorts            one-hot, SRAM result valid for port (grant+1)
// rsp_tag_only_o   out  1                   tag-only flag of the request in rsp stage
// wr_cl_vld_i      in   1                   cacheline refill/invalidate owns the arrays
// wr_req_i         in   1                   single-word write request
// wr_ack_o         out  1                   single-word write granted
// sram_req_o       out  1                   SRAM read enable
// sram_tag_o       out  TagWidth            tag of granted port
// sram_idx_o       out  IdxWidth            index of granted port
// sram_off_o       out  OffWidth            offset of granted port
// sram_tag_only_o  out  1                   tag-only flag of granted port
// BEHAVIOUR
// - Reset/clr_i: rr_hi_q=0, rr_lo_q=0, starve_q=0, rsp_vld_q=0, rsp_tag_only_q=0.
//   All combinational outputs are 0 while no request is present.
// - Grant is combinational. wr_cl_vld_i=1 -> no read grant, wr_ack_o=0. Starve_q holds.
// - Normal priority: high-prio reads > word write > low-prio reads.
//   high grant: round-robin among k with rd_req_i[k]&rd_prio_i[k], start at rr_hi_q.
//   wr_ack_o = wr_req_i & no high-prio request & ~wr_cl_vld_i.
//   low grant: round-robin from rr_lo_q, only if no high-prio request and no wr_req_i.
// - Forced mode (starve_q==StarveLimit & any low-prio request): low-prio grant wins
//   over high-prio reads and over word write (wr_ack_o=0). wr_cl_vld_i still blocks.
// - starve_q (width $clog2(StarveLimit+1)): +1 per cycle with a pending low-prio request,
//   no low grant, and wr_cl_vld_i=0. Saturates at StarveLimit. Cleared on low grant or
//   when no low-prio request is pending.
// - Pointers: on grant of port g in a class, that class pointer <= (g+1) mod NumPorts.
//   Wrap NumPorts-1 -> 0. Other class pointer unchanged.
// - At most one rd_ack_o bit per cycle. rd_ack_o and wr_ack_o are never both 1.
// - sram_req_o = |rd_ack_o. sram_* mux granted port's fields, 0 when no grant.
// - Response stage: rsp_vld_q <= rd_ack_o, rsp_tag_only_q <= sram_tag_only_o.
//   rsp_vld_o = rsp_vld_q. Latency grant->rsp_vld_o = 1 cycle. Back-to-back grants allowed.
// - Requester changing fields while waiting is legal; the granted cycle's values are used.
// - Reset mid-operation: a pending rsp_vld is dropped. Requesters re-issue.
// TESTING
// - Ports 0,1 high, 2 low. req=3'b011 for 4 cycles -> acks 001,010,001,010; rsp_vld lags 1 cycle.
// - req=3'b111, wr_req_i=1, wr_cl_vld_i=1 -> all acks 0, wr_ack 0. Drop wr_cl_vld -> hi ack only.
// - req[1:0]=11 continuously, req[2]=1, StarveLimit=4 -> port 2 acked in cycle 5, starve_q back to 0.
// - Only wr_req_i and req[2] -> wr_ack_o=1 while rd_ack_o=0. Release wr_req -> rd_ack_o=3'b100.
// - Grant port 1 (rsp pending), assert rst_ni=0 -> rsp_vld_o=0, rr pointers 0.
// - Random req/prio/wr_cl_vld/wr_req for 10k cycles: one-hot acks, no low-prio wait > StarveLimit+1.

Source files
------------

// File: rtl/wt_dcache_rd_arb.sv
// ------------------------------------------------------------------------------------------------
// wt_dcache_rd_arb
//
// Read-port arbiter for the write-through L1 dcache tag/data SRAMs. One SRAM read port is shared
// by several requesters. High-priority requesters (load unit, PTW) are served round-robin ahead
// of the single-word write port, which in turn is ahead of low-priority requesters (write
// buffer), also served round-robin. A starvation counter forces a low-priority grant once it
// has waited StarveLimit cycles. A cacheline refill/invalidate owns the arrays outright and
// blocks every grant while active. Each read grant is tracked through a one-cycle response
// stage so the SRAM result is tagged with the requester that issued it.
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous reset, active low
//   clr_i            synchronous clear, active high
//   rd_req_i         read request per port, held until acknowledged
//   rd_prio_i        per-port static priority, 1 = high
//   rd_tag_only_i    per-port tag-array-only read flag
//   rd_tag_i         packed per-port tags
//   rd_idx_i         packed per-port cacheline indices
//   rd_off_i         packed per-port byte offsets
//   rd_ack_o         one-hot read grant, combinational in the request cycle
//   rsp_vld_o        one-hot, SRAM result valid for that port (grant + 1 cycle)
//   rsp_tag_only_o   tag-only flag of the request now in the response stage
//   wr_cl_vld_i      cacheline refill/invalidate owns the arrays this cycle
//   wr_req_i         single-word write request
//   wr_ack_o         single-word write granted
//   sram_req_o       SRAM read enable
//   sram_tag_o       tag of the granted port
//   sram_idx_o       index of the granted port
//   sram_off_o       offset of the granted port
//   sram_tag_only_o  tag-only flag of the granted port
// ------------------------------------------------------------------------------------------------
module wt_dcache_rd_arb #(
    parameter int unsigned NumPorts    = 3,
    parameter int unsigned TagWidth    = 28,
    parameter int unsigned IdxWidth    = 8,
    parameter int unsigned OffWidth    = 4,
    parameter int unsigned StarveLimit = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    input  logic [NumPorts-1:0]          rd_req_i,
    input  logic [NumPorts-1:0]          rd_prio_i,
    input  logic [NumPorts-1:0]          rd_tag_only_i,
    input  logic [NumPorts*TagWidth-1:0] rd_tag_i,
    input  logic [NumPorts*IdxWidth-1:0] rd_idx_i,
    input  logic [NumPorts*OffWidth-1:0] rd_off_i,
    output logic [NumPorts-1:0]          rd_ack_o,
    output logic [NumPorts-1:0]          rsp_vld_o,
    output logic                         rsp_tag_only_o,
    input  logic                         wr_cl_vld_i,
    input  logic                         wr_req_i,
    output logic                         wr_ack_o,
    output logic                         sram_req_o,
    output logic [TagWidth-1:0]          sram_tag_o,
    output logic [IdxWidth-1:0]          sram_idx_o,
    output logic [OffWidth-1:0]          sram_off_o,
    output logic                         sram_tag_only_o
);

    localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned StW  = $clog2(StarveLimit + 1);

    localparam logic [StW-1:0]  StarveMax = StW'(StarveLimit);
    localparam logic [PtrW-1:0] LastPort  = PtrW'(NumPorts - 1);

    // Round-robin pick: first requesting port at or after ptr, wrapping. Returns one-hot.
    function automatic logic [NumPorts-1:0] rr_pick(input logic [NumPorts-1:0] req,
                                                    input logic [PtrW-1:0]     ptr);
        logic [NumPorts-1:0] gnt;
        logic                found;
        logic [PtrW-1:0]     idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            idx = PtrW'((32'(ptr) + i) % NumPorts);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [PtrW-1:0] oh_to_idx(input logic [NumPorts-1:0] oh);
        logic [PtrW-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < NumPorts; k++) begin
            if (oh[k]) idx = idx | PtrW'(k);
        end
        return idx;
    endfunction

    // Pointer moves to the port after the one just granted, wrapping to 0.
    function automatic logic [PtrW-1:0] next_ptr(input logic [NumPorts-1:0] oh);
        logic [PtrW-1:0] g;
        g = oh_to_idx(oh);
        return (g == LastPort) ? '0 : g + PtrW'(1);
    endfunction

    // --------------------------------------------------------------------------------------------
    // State
    // --------------------------------------------------------------------------------------------
    logic [PtrW-1:0]     r_rr_hi_q, r_rr_hi_d;
    logic [PtrW-1:0]     r_rr_lo_q, r_rr_lo_d;
    logic [StW-1:0]      r_starve_q, r_starve_d;
    logic [NumPorts-1:0] r_rsp_vld_q;
    logic                r_rsp_tag_only_q;

    // --------------------------------------------------------------------------------------------
    // Request classification and arbitration
    // --------------------------------------------------------------------------------------------
    logic [NumPorts-1:0] w_hi_req, w_lo_req;
    logic                w_hi_any, w_lo_any;
    logic                w_forced;
    logic [NumPorts-1:0] w_hi_pick, w_lo_pick;
    logic                w_hi_gnt, w_lo_gnt;
    logic                w_wr_gnt;
    logic [NumPorts-1:0] w_rd_ack;

    assign w_hi_req  = rd_req_i & rd_prio_i;
    assign w_lo_req  = rd_req_i & ~rd_prio_i;
    assign w_hi_any  = |w_hi_req;
    assign w_lo_any  = |w_lo_req;
    assign w_forced  = w_lo_any && (r_starve_q == StarveMax);
    assign w_hi_pick = rr_pick(w_hi_req, r_rr_hi_q);
    assign w_lo_pick = rr_pick(w_lo_req, r_rr_lo_q);

    always_comb begin
        w_hi_gnt = 1'b0;
        w_lo_gnt = 1'b0;
        w_wr_gnt = 1'b0;
        // Refill/invalidate owns the arrays: nothing else may touch them this cycle.
        if (!wr_cl_vld_i) begin
            if (w_forced) begin
                w_lo_gnt = 1'b1;
            end else if (w_hi_any) begin
                w_hi_gnt = 1'b1;
            end else if (wr_req_i) begin
                w_wr_gnt = 1'b1;
            end else if (w_lo_any) begin
                w_lo_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_ack = '0;
        if (w_hi_gnt) begin
            w_rd_ack = w_hi_pick;
        end else if (w_lo_gnt) begin
            w_rd_ack = w_lo_pick;
        end
    end

    assign rd_ack_o   = w_rd_ack;
    assign wr_ack_o   = w_wr_gnt;
    assign sram_req_o = |w_rd_ack;

    // --------------------------------------------------------------------------------------------
    // SRAM address mux (AND-OR over the one-hot grant; zero when nothing granted)
    // --------------------------------------------------------------------------------------------
    always_comb begin
        sram_tag_o      = '0;
        sram_idx_o      = '0;
        sram_off_o      = '0;
        sram_tag_only_o = 1'b0;
        for (int unsigned k = 0; k < NumPorts; k++) begin
            if (w_rd_ack[k]) begin
                sram_tag_o      = sram_tag_o | rd_tag_i[k*TagWidth +: TagWidth];
                sram_idx_o      = sram_idx_o | rd_idx_i[k*IdxWidth +: IdxWidth];
                sram_off_o      = sram_off_o | rd_off_i[k*OffWidth +: OffWidth];
                sram_tag_only_o = sram_tag_only_o | rd_tag_only_i[k];
            end
        end
    end

    // --------------------------------------------------------------------------------------------
    // Next-state: round-robin pointers and starvation counter
    // --------------------------------------------------------------------------------------------
    always_comb begin
        r_rr_hi_d = r_rr_hi_q;
        r_rr_lo_d = r_rr_lo_q;
        if (w_hi_gnt) r_rr_hi_d = next_ptr(w_hi_pick);
        if (w_lo_gnt) r_rr_lo_d = next_ptr(w_lo_pick);
    end

    always_comb begin
        r_starve_d = r_starve_q;
        if (!w_lo_any || w_lo_gnt) begin
            r_starve_d = '0;
        end else if (!wr_cl_vld_i && (r_starve_q != StarveMax)) begin
            // Refill cycles are not counted: nobody could have been served then.
            r_starve_d = r_starve_q + StW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_hi_q        <= '0;
            r_rr_lo_q        <= '0;
            r_starve_q       <= '0;
            r_rsp_vld_q      <= '0;
            r_rsp_tag_only_q <= 1'b0;
        end else if (clr_i) begin
            r_rr_hi_q        <= '0;
            r_rr_lo_q        <= '0;
            r_starve_q       <= '0;
            r_rsp_vld_q      <= '0;
            r_rsp_tag_only_q <= 1'b0;
        end else begin
            r_rr_hi_q        <= r_rr_hi_d;
            r_rr_lo_q        <= r_rr_lo_d;
            r_starve_q       <= r_starve_d;
            r_rsp_vld_q      <= w_rd_ack;
            r_rsp_tag_only_q <= sram_tag_only_o;
        end
    end

    assign rsp_vld_o      = r_rsp_vld_q;
    assign rsp_tag_only_o = r_rsp_tag_only_q;

    // --------------------------------------------------------------------------------------------
    // Invariants
    // --------------------------------------------------------------------------------------------
    always_comb begin
        if (rst_ni) begin
            assert ($countones(w_rd_ack) <= 1)
                else $error("rd_ack_o not one-hot: %b", w_rd_ack);
            assert (!(sram_req_o && wr_ack_o))
                else $error("read and word write granted together");
            assert (!(wr_cl_vld_i && (sram_req_o || wr_ack_o)))
                else $error("grant issued during cacheline refill");
        end
    end

endmodule
